// File: rtl/nap_countdown.sv
// Nap countdown engine: loads a clamped BCD m:ss setting, counts it down once per
// prescaled second and holds an alarm at 0:00. Optional snooze under NAP_SNOOZE_EN.
module nap_countdown #(
    parameter int CLK_HZ     = 1000,
    parameter int ALARM_SECS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       completeSetting,
    input  logic [3:0] one_sec,
    input  logic [3:0] ten_sec,
    input  logic [3:0] one_min,
    input  logic       cancel,
    input  logic       snooze,
    output logic [3:0] rem_one_sec,
    output logic [3:0] rem_ten_sec,
    output logic [3:0] rem_one_min,
    output logic       running,
    output logic       alarm,
    output logic       sec_tick
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    localparam int             PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0]  PRESC_ZERO = PW'(0);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);
    localparam logic [7:0]     ALARM_LAST = 8'(ALARM_SECS - 1);
    localparam logic [11:0]    SNOOZE_VAL = 12'h005;

    // Saturate a BCD digit at its upper limit.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        if (d > lim) begin
            return lim;
        end else begin
            return d;
        end
    endfunction

    // Decrement {min, ten, one} by one second; 0:00 is held rather than wrapped.
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] m, t, o;
        m = v[11:8];
        t = v[7:4];
        o = v[3:0];
        if (v == 12'h000) begin
            return 12'h000;
        end else if (o != 4'd0) begin
            return {m, t, o - 4'd1};
        end else if (t != 4'd0) begin
            return {m, t - 4'd1, 4'd9};
        end else begin
            return {m - 4'd1, 4'd5, 4'd9};
        end
    endfunction

    state_t         state_r, state_s;
    logic [PW-1:0]  presc_r, presc_s;
    logic [7:0]     alarm_cnt_r, alarm_cnt_s;
    logic [11:0]    rem_r, rem_s;
    logic           hist_r;
    logic           tick_r, tick_s;
    logic           load_s;
    logic           snooze_req_s;
    logic           tick_due_s;
    logic [11:0]    load_val_s;
    logic [11:0]    dec_val_s;

`ifdef NAP_SNOOZE_EN
    assign snooze_req_s = snooze;
`else
    logic unused_snooze_s;
    assign unused_snooze_s = snooze;
    assign snooze_req_s    = 1'b0;
`endif

    assign load_s     = completeSetting & ~hist_r;
    assign load_val_s = {clamp_digit(one_min, 4'd9), clamp_digit(ten_sec, 4'd5),
                         clamp_digit(one_sec, 4'd9)};
    assign tick_due_s = (state_r != ST_IDLE) && (presc_r == PRESC_LAST);
    assign dec_val_s  = bcd_dec(rem_r);

    // Next-state logic: cancel > load > snooze > second tick.
    always_comb begin
        state_s     = state_r;
        presc_s     = presc_r;
        alarm_cnt_s = alarm_cnt_r;
        rem_s       = rem_r;
        tick_s      = 1'b0;
        if (cancel) begin
            state_s     = ST_IDLE;
            rem_s       = 12'h000;
            presc_s     = PRESC_ZERO;
            alarm_cnt_s = 8'd0;
        end else if (load_s) begin
            presc_s     = PRESC_ZERO;
            alarm_cnt_s = 8'd0;
            if (load_val_s != 12'h000) begin
                state_s = ST_RUN;
                rem_s   = load_val_s;
            end else begin
                state_s = ST_IDLE;
                rem_s   = 12'h000;
            end
        end else if (snooze_req_s && (state_r == ST_ALARM)) begin
            state_s     = ST_RUN;
            rem_s       = SNOOZE_VAL;
            presc_s     = PRESC_ZERO;
            alarm_cnt_s = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    presc_s = PRESC_ZERO;
                end
                ST_RUN: begin
                    if (tick_due_s) begin
                        tick_s  = 1'b1;
                        presc_s = PRESC_ZERO;
                        rem_s   = dec_val_s;
                        if (dec_val_s == 12'h000) begin
                            state_s     = ST_ALARM;
                            alarm_cnt_s = 8'd0;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        presc_s = presc_r + PRESC_ONE;
                    end
                end
                ST_ALARM: begin
                    rem_s = 12'h000;
                    if (tick_due_s) begin
                        tick_s  = 1'b1;
                        presc_s = PRESC_ZERO;
                        if (alarm_cnt_r >= ALARM_LAST) begin
                            state_s     = ST_IDLE;
                            alarm_cnt_s = 8'd0;
                        end else begin
                            alarm_cnt_s = alarm_cnt_r + 8'd1;
                        end
                    end else begin
                        presc_s = presc_r + PRESC_ONE;
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    rem_s       = 12'h000;
                    presc_s     = PRESC_ZERO;
                    alarm_cnt_s = 8'd0;
                end
            endcase
        end
    end

    // State, counters, digits and setting-edge history.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            presc_r     <= PRESC_ZERO;
            alarm_cnt_r <= 8'd0;
            rem_r       <= 12'h000;
            hist_r      <= 1'b0;
            tick_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            presc_r     <= presc_s;
            alarm_cnt_r <= alarm_cnt_s;
            rem_r       <= rem_s;
            hist_r      <= completeSetting;
            tick_r      <= tick_s;
        end
    end

    assign rem_one_min = rem_r[11:8];
    assign rem_ten_sec = rem_r[7:4];
    assign rem_one_sec = rem_r[3:0];
    assign running     = (state_r == ST_RUN);
    assign alarm       = (state_r == ST_ALARM);
    assign sec_tick    = tick_r;

endmodule
